// File: rtl/uart_pkg.sv
// Shared UART types: arbiter FSM state encoding.
package uart_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'b00,
        ARB_LOCK = 2'b01
    } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request strictly after i_ptr, wrapping.
module rr_arbiter #(
    parameter int unsigned NREQ = 4
) (
    input  logic [NREQ-1:0]         i_req,
    input  logic [$clog2(NREQ)-1:0] i_ptr,
    output logic [NREQ-1:0]         o_gnt,
    output logic [$clog2(NREQ)-1:0] o_idx,
    output logic                    o_any
);

    localparam int unsigned IW = $clog2(NREQ);

    logic [IW-1:0] cand;

    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        o_any = 1'b0;
        cand  = '0;
        for (int unsigned i = 1; i <= NREQ; i++) begin
            cand = IW'((32'(i_ptr) + i) % NREQ);
            if (!o_any && i_req[cand]) begin
                o_any       = 1'b1;
                o_gnt[cand] = 1'b1;
                o_idx       = cand;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arb.sv
// Packet-granular round-robin arbiter muxing NREQ byte streams onto one UART transmitter,
// with a stall timeout that revokes a grant from a requester that stops sending mid-packet.
module uart_tx_arb
    import uart_pkg::*;
#(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned DLEN    = 8,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      i_req_valid,
    output logic [NREQ-1:0]      o_req_ready,
    input  logic [NREQ*DLEN-1:0] i_req_data,
    input  logic [NREQ-1:0]      i_req_last,
    output logic                 o_wvalid,
    input  logic                 i_wready,
    output logic [DLEN-1:0]      o_wdata,
    output logic [NREQ-1:0]      o_grant,
    output logic                 o_timeout
);

    localparam int unsigned IW = $clog2(NREQ);
    localparam int unsigned SW = $clog2(TIMEOUT + 1);

    arb_state_e    state_q, state_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [SW-1:0] stall_q, stall_d;
    logic          timeout_q, timeout_d;

    logic [NREQ-1:0] rr_gnt;
    logic [IW-1:0]   rr_idx;
    logic            rr_any;
    logic            hs;

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_rr (
        .i_req (i_req_valid),
        .i_ptr (ptr_q),
        .o_gnt (rr_gnt),
        .o_idx (rr_idx),
        .o_any (rr_any)
    );

    always_comb begin
        o_wvalid    = 1'b0;
        o_wdata     = '0;
        o_req_ready = '0;
        o_grant     = '0;
        if (state_q == ARB_LOCK) begin
            o_wvalid           = i_req_valid[idx_q];
            o_wdata            = i_req_data[32'(idx_q) * DLEN +: DLEN];
            o_req_ready[idx_q] = i_wready;
            o_grant            = grant_q;
        end
    end

    assign hs        = o_wvalid && i_wready;
    assign o_timeout = timeout_q;

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        idx_d     = idx_q;
        ptr_d     = ptr_q;
        stall_d   = stall_q;
        timeout_d = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (rr_any) begin
                    state_d = ARB_LOCK;
                    grant_d = rr_gnt;
                    idx_d   = rr_idx;
                    stall_d = '0;
                end
            end
            ARB_LOCK: begin
                if (hs) begin
                    stall_d = '0;
                    if (i_req_last[idx_q]) begin
                        state_d = ARB_IDLE;
                        grant_d = '0;
                        ptr_d   = idx_q;
                    end
                end else if (!i_req_valid[idx_q]) begin
                    // Revoke as the count reaches TIMEOUT-1: pulse lands TIMEOUT cycles after
                    // the last handshake. Transmitter backpressure never counts.
                    if (stall_q >= SW'(TIMEOUT - 2)) begin
                        state_d   = ARB_IDLE;
                        grant_d   = '0;
                        ptr_d     = idx_q;
                        timeout_d = 1'b1;
                    end else if (stall_q != '1) begin
                        stall_d = stall_q + SW'(1);
                    end
                end
            end
            default: begin
                state_d = ARB_IDLE;
                grant_d = '0;
                stall_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ARB_IDLE;
            grant_q   <= '0;
            idx_q     <= '0;
            ptr_q     <= IW'(NREQ - 1);
            stall_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            idx_q     <= idx_d;
            ptr_q     <= ptr_d;
            stall_q   <= stall_d;
            timeout_q <= timeout_d;
        end
    end

endmodule
